// File: rtl/key_debounce.sv
// key_debounce
//
// Input conditioning for the six board push-buttons. Each raw, active-low,
// asynchronous button passes through a two-flop synchroniser. A per-key
// debounce FSM then accepts a press or a release only after the synchronised
// level has been stable for DEBOUNCE_CNT cycles. Every accepted press gives
// a one-cycle strobe on key_pulse.
//
// Optional feature, enabled by defining the macro KEY_REPEAT_EN:
//   Keys whose REPEAT_MASK bit is set emit extra repeat strobes while held.
//   The first repeat comes REPEAT_DELAY cycles after the press strobe.
//   Later repeats come every REPEAT_PERIOD cycles.
//   Without the macro, the hold counters do not exist and each press gives
//   exactly one strobe.
//
// Ports:
//   pixel_clk  in   clock
//   sys_rst_n  in   asynchronous active-low reset
//   key_in     in   [5:0] raw buttons, active-low, asynchronous
//   key_pulse  out  [5:0] one-cycle press/repeat strobe per key
//   key_level  out  [5:0] debounced held level, active-high
//   key_any    out  OR of key_pulse, registered in the same cycle

module key_debounce #(
    parameter int         DEBOUNCE_CNT  = 500_000,
    parameter int         REPEAT_DELAY  = 12_500_000,
    parameter int         REPEAT_PERIOD = 2_500_000,
    parameter logic [5:0] REPEAT_MASK   = 6'b001111
) (
    input  logic       pixel_clk,
    input  logic       sys_rst_n,
    input  logic [5:0] key_in,
    output logic [5:0] key_pulse,
    output logic [5:0] key_level,
    output logic       key_any
);

    // A single width is shared by the debounce and hold counters. It is
    // sized from the largest timing parameter.
    localparam int MAX_DR = (DEBOUNCE_CNT > REPEAT_DELAY) ? DEBOUNCE_CNT : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CNT_W  = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [5:0] sync1;
    logic [5:0] sync2;
    logic [5:0] pulse_nxt;
    logic [5:0] level_nxt;

    // The synchroniser resets to the released level (1). A key held through
    // reset release is therefore seen as a fresh falling edge and debounced
    // like any other press.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`else
    logic unused_repeat_mask;
    assign unused_repeat_mask = ^REPEAT_MASK;
`endif

    for (genvar k = 0; k < 6; k++) begin : g_key
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             pressed;
        logic             pulse_k;
`ifdef KEY_REPEAT_EN
        logic [CNT_W-1:0] hold_cnt;
        logic [CNT_W-1:0] hold_nxt;
        logic             repeating;
        logic             repeating_nxt;
`endif

        assign pressed = ~sync2[k];

        // hold_cnt counts towards the next repeat strobe. The counter
        // restarts after each strobe, and "repeating" selects between the
        // initial delay and the shorter period. Any state other than
        // PRESSED clears both.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            pulse_k   = 1'b0;
`ifdef KEY_REPEAT_EN
            hold_nxt      = '0;
            repeating_nxt = 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                        pulse_k   = 1'b1;
                    end else begin
                        cnt_nxt = sat_inc(cnt);
                    end
                end
                PRESSED: begin
                    if (!pressed) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = '0;
                    end else begin
`ifdef KEY_REPEAT_EN
                        if (REPEAT_MASK[k]) begin
                            repeating_nxt = repeating;
                            if (hold_cnt == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
                                pulse_k       = 1'b1;
                                hold_nxt      = '0;
                                repeating_nxt = 1'b1;
                            end else begin
                                hold_nxt = sat_inc(hold_cnt);
                            end
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = sat_inc(cnt);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state <= IDLE;
                cnt   <= '0;
`ifdef KEY_REPEAT_EN
                hold_cnt  <= '0;
                repeating <= 1'b0;
`endif
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
`ifdef KEY_REPEAT_EN
                hold_cnt  <= hold_nxt;
                repeating <= repeating_nxt;
`endif
            end
        end

        assign pulse_nxt[k] = pulse_k;
        assign level_nxt[k] = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
    end

    // The outputs are registered from next-state values, so they change on
    // the same edge as the FSM transition and have no path from key_in.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_pulse <= '0;
            key_level <= '0;
            key_any   <= 1'b0;
        end else begin
            key_pulse <= pulse_nxt;
            key_level <= level_nxt;
            key_any   <= |pulse_nxt;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//
// Scoreboard bench for key_debounce with DEBOUNCE_CNT=4, REPEAT_DELAY=10 and
// REPEAT_PERIOD=3. The stimulus side drives key_in and sys_rst_n on falling
// edges. It predicts the outputs after the next rising edge with a
// run-length reference model and queues the prediction. A monitor pops one
// prediction per cycle, shortly after each rising edge, and compares.
// Directed scenarios also check per-key pulse totals against fixed values.

module tb_key_debounce;

    localparam int         DEB   = 4;
    localparam int         RDLY  = 10;
    localparam int         RPER  = 3;
    localparam logic [5:0] RMASK = 6'b001111;
`ifdef KEY_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic       pixel_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [5:0] key_in    = 6'b111111;
    logic [5:0] key_pulse;
    logic [5:0] key_level;
    logic       key_any;

    key_debounce #(
        .DEBOUNCE_CNT (DEB),
        .REPEAT_DELAY (RDLY),
        .REPEAT_PERIOD(RPER),
        .REPEAT_MASK  (RMASK)
    ) dut (
        .pixel_clk(pixel_clk),
        .sys_rst_n(sys_rst_n),
        .key_in   (key_in),
        .key_pulse(key_pulse),
        .key_level(key_level),
        .key_any  (key_any)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct packed {
        logic [5:0] pulse;
        logic [5:0] level;
        logic       any;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared = 0;
    int   n_mismatch = 0;
    int   cycle_no   = 0;
    int   pulse_seen[6];
    int   base_seen[6];

    // Reference model state. m_pipe holds the two sampled raw values not yet
    // seen by the debouncer. m_run counts consecutive samples that disagree
    // with the debounced level. m_age counts cycles held in the settled
    // pressed condition.
    logic [5:0] m_s1 = 6'b111111;
    logic [5:0] m_s2 = 6'b111111;
    logic [5:0] m_level = 6'b0;
    int         m_run[6];
    int         m_age[6];

    function automatic bit isRepeatAge(input int age);
        return (age == RDLY) || (age > RDLY && ((age - RDLY) % RPER) == 0);
    endfunction

    task automatic modelStep(input logic [5:0] keys, input logic rst_n);
        exp_t e;
        e = '0;
        if (!rst_n) begin
            m_s1    = 6'b111111;
            m_s2    = 6'b111111;
            m_level = 6'b0;
            for (int k = 0; k < 6; k++) begin
                m_run[k] = 0;
                m_age[k] = 0;
            end
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (!m_level[k]) begin
                    m_run[k] = !m_s2[k] ? m_run[k] + 1 : 0;
                    if (m_run[k] == DEB + 1) begin
                        m_level[k]  = 1'b1;
                        m_run[k]    = 0;
                        m_age[k]    = 0;
                        e.pulse[k]  = 1'b1;
                    end
                end else if (!m_s2[k]) begin
                    if (m_run[k] == 0) begin
                        m_age[k] = m_age[k] + 1;
                        if (REPEAT_ON && RMASK[k] && isRepeatAge(m_age[k]))
                            e.pulse[k] = 1'b1;
                    end else begin
                        m_run[k] = 0;
                        m_age[k] = 0;
                    end
                end else begin
                    m_run[k] = m_run[k] + 1;
                    m_age[k] = 0;
                    if (m_run[k] == DEB + 1) begin
                        m_level[k] = 1'b0;
                        m_run[k]   = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = keys;
        end
        e.level = m_level;
        e.any   = |e.pulse;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [5:0] keys, input logic rst_n, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge pixel_clk);
            key_in    = keys;
            sys_rst_n = rst_n;
            modelStep(keys, rst_n);
        end
    endtask

    task automatic checkOutput(input string name, input int got, input int expected);
        n_compared++;
        if (got != expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expected);
        end
    endtask

    task automatic takeSnapshot();
        for (int k = 0; k < 6; k++) base_seen[k] = pulse_seen[k];
    endtask

    task automatic checkPulses(input string name, input int k, input int expected);
        checkOutput($sformatf("%s key%0d pulses", name, k), pulse_seen[k] - base_seen[k], expected);
    endtask

    // Monitor: one prediction is due per rising edge once stimulus starts.
    initial begin
        for (int k = 0; k < 6; k++) pulse_seen[k] = 0;
        forever begin
            @(posedge pixel_clk);
            #2;
            cycle_no++;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_compared++;
                if ({key_pulse, key_level, key_any} !== e) begin
                    n_mismatch++;
                    $display("[TB] FAIL outputs@cycle%0d: got pulse=%b level=%b any=%b, expected pulse=%b level=%b any=%b",
                             cycle_no, key_pulse, key_level, key_any, e.pulse, e.level, e.any);
                end
                for (int k = 0; k < 6; k++)
                    if (key_pulse[k] === 1'b1) pulse_seen[k]++;
            end
        end
    end

    initial begin
        logic [5:0] cur;
        for (int k = 0; k < 6; k++) begin
            m_run[k] = 0;
            m_age[k] = 0;
            base_seen[k] = 0;
        end

        $display("[TB] reset with all keys held");
        applyStimulus(6'b000000, 1'b0, 3);
        takeSnapshot();
        applyStimulus(6'b000000, 1'b1, 10);
        applyStimulus(6'b111111, 1'b1, 12);
        for (int k = 0; k < 6; k++) checkPulses("reset-held", k, 1);

        $display("[TB] clean press key4");
        takeSnapshot();
        applyStimulus(6'b101111, 1'b1, 20);
        applyStimulus(6'b111111, 1'b1, 12);
        checkPulses("clean", 4, 1);

        $display("[TB] bounce key5");
        takeSnapshot();
        applyStimulus(6'b011111, 1'b1, 3);
        applyStimulus(6'b111111, 1'b1, 1);
        applyStimulus(6'b011111, 1'b1, 2);
        applyStimulus(6'b111111, 1'b1, 12);
        checkPulses("bounce", 5, 0);

        $display("[TB] release bounce key0");
        takeSnapshot();
        applyStimulus(6'b111110, 1'b1, 10);
        applyStimulus(6'b111111, 1'b1, 2);
        applyStimulus(6'b111110, 1'b1, 1);
        applyStimulus(6'b111111, 1'b1, 12);
        checkPulses("release-bounce", 0, 1);

        $display("[TB] simultaneous keys 4 and 5");
        takeSnapshot();
        applyStimulus(6'b001111, 1'b1, 10);
        applyStimulus(6'b111111, 1'b1, 12);
        checkPulses("simultaneous", 4, 1);
        checkPulses("simultaneous", 5, 1);

        $display("[TB] long hold keys 2 and 4");
        takeSnapshot();
        applyStimulus(6'b101011, 1'b1, 22);
        applyStimulus(6'b111111, 1'b1, 12);
        checkPulses("hold", 2, REPEAT_ON ? 4 : 1);
        checkPulses("hold", 4, 1);

        $display("[TB] randomized traffic");
        cur = 6'b111111;
        for (int i = 0; i < 1500; i++) begin
            int flip_range;
            flip_range = (i < 750) ? 7 : 29;
            for (int k = 0; k < 6; k++)
                if ($urandom_range(0, flip_range) == 0) cur[k] = ~cur[k];
            if ($urandom_range(0, 399) == 0)
                applyStimulus(cur, 1'b0, 2);
            else
                applyStimulus(cur, 1'b1, 1);
        end
        applyStimulus(6'b111111, 1'b1, 15);

        @(posedge pixel_clk);
        #3;
        checkOutput("queue drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
